bin2bcd_seq: RTL

Sequential binary-to-BCD encoder using the shift-and-add-3 (double-dabble) method. It accepts one unsigned binary value through a valid/ready handshake. It produces the four BCD digits (ones, tens, hundreds, thousands) that the seven-segment display controller consumes. It sits between the counter/datapath logic and the display multiplexer, and inputs above 9999 are saturated.

---
 rtl/bin2bcd_seq.sv | 81 ++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD encoder with saturation
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int SAT_VAL = 9999
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundreds,
  output logic [3:0]       thousands,
  output logic             out_valid,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [BIN_W-1:0] bin_sr;
  logic [15:0] bcd_sr, bcd_adj;
  logic [15+BIN_W:0] cat_nx;
  logic [4:0] iter;
  logic sat_pend, sat, accept, done;
  assign in_ready = state == IDLE;
  assign busy = !in_ready;
  assign accept = in_ready && in_valid;
  assign done = state == SHIFT && iter == 5'(BIN_W - 1);
  assign sat = 17'(bin_in) > 17'(SAT_VAL);
  assign cat_nx = {bcd_adj, bin_sr} << 1;
  // add 3 to every BCD nibble that would overflow past 9 when doubled
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i+:4] = bcd_sr[4*i+:4] >= 4'd5 ? bcd_sr[4*i+:4] + 4'd3 : bcd_sr[4*i+:4];
  end
  // state register
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state: leave IDLE on accept, return after the last shift
  always_comb begin
    state_nx = state;
    if (accept) state_nx = SHIFT;
    else if (done) state_nx = IDLE;
  end
  // shift datapath and registered result
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      iter      <= '0;
      sat_pend  <= 1'b0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
      thousands <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= done;
      if (accept) begin
        bin_sr   <= sat ? BIN_W'(SAT_VAL) : bin_in;
        sat_pend <= sat;
        bcd_sr   <= '0;
        iter     <= '0;
      end else if (state == SHIFT) begin
        bcd_sr <= cat_nx[15+BIN_W -: 16];
        bin_sr <= cat_nx[BIN_W-1:0];
        iter   <= iter + 5'd1;
        if (done) begin
          ones      <= cat_nx[BIN_W +: 4];
          tens      <= cat_nx[BIN_W+4 +: 4];
          hundreds  <= cat_nx[BIN_W+8 +: 4];
          thousands <= cat_nx[BIN_W+12 +: 4];
          overflow  <= sat_pend;
        end
      end
    end
endmodule
